// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the core clock PLL: pulses the PLL reset, waits for a
// stable synchronized lock, releases the core, and retries or faults on timeout.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic       lol_pulse,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_A = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRIES);
  localparam logic             STB_ONE   = (LOCK_STABLE_CYCLES == 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_retry_next;
  logic             w_lol_next;
  logic             r_fresh;
  logic             r_sync1;
  logic             r_lk_s;

  // Two-flop synchronizer for the asynchronous PLL lock output.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_lk_s  <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_lk_s  <= r_sync1;
    end
  end

  // Next state, shared counter and retry bookkeeping.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    w_retry_next = retry_cnt;
    w_lol_next   = 1'b0;

    if (relock_req) begin
      w_state_next = S_RESET_PLL;
      w_cnt_next   = '0;
      w_retry_next = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          // The first cycle out of reset is the entry cycle of the PLL reset pulse.
          if (r_fresh) begin
            w_cnt_next = '0;
          end else if (r_cnt == RST_LAST) begin
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s) begin
            if (STB_ONE) begin
              w_state_next = S_RUN;
              w_cnt_next   = '0;
              w_retry_next = '0;
            end else begin
              w_state_next = S_STABLE;
              w_cnt_next   = CNT_W'(1);
            end
          end else if (r_cnt == TO_LAST) begin
            w_cnt_next = '0;
            if (retry_cnt == RETRY_LIM) begin
              w_state_next = S_FAULT;
            end else begin
              w_state_next = S_RESET_PLL;
              w_retry_next = retry_cnt + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!r_lk_s) begin
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
          end else if (r_cnt >= STB_LAST) begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
            w_retry_next = '0;
          end
        end
        S_RUN: begin
          if (!r_lk_s) begin
            w_state_next = S_RESET_PLL;
            w_cnt_next   = '0;
            w_lol_next   = 1'b1;
          end
        end
        S_FAULT: begin
          w_state_next = S_FAULT;
        end
        default: begin
          w_state_next = S_RESET_PLL;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= S_RESET_PLL;
      r_cnt     <= '0;
      r_fresh   <= 1'b1;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lol_pulse <= 1'b0;
      retry_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_fresh   <= 1'b0;
      pll_rst   <= (w_state_next == S_RESET_PLL) || (w_state_next == S_FAULT);
      sys_rst   <= (w_state_next != S_RUN);
      ready     <= (w_state_next == S_RUN);
      fault     <= (w_state_next == S_FAULT);
      lol_pulse <= w_lol_next;
      retry_cnt <= w_retry_next;
    end
  end

endmodule
